// File: rtl/unisim_sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : unisim_sram_pkg
//  Description : Shared constants and geometry helpers for the tiled SRAM.
//                Every physical bank is 2048 words of 8 bits.
//  Revision    : 1.0  initial release
// ============================================================================
package unisim_sram_pkg;

  localparam int BANK_W     = 8;
  localparam int BANK_AW    = 11;
  localparam int BANK_DEPTH = 1 << BANK_AW;

  typedef logic [BANK_W-1:0]  bank_data_t;
  typedef logic [BANK_AW-1:0] bank_addr_t;

  // Number of byte-wide banks placed side by side to form one word.
  function automatic int calc_nh(input int data_w);
    return data_w / BANK_W;
  endfunction

  // Number of bank rows stacked to reach the requested depth; at least one.
  function automatic int calc_nv(input int addr_w);
    return (addr_w > BANK_AW) ? (1 << (addr_w - BANK_AW)) : 1;
  endfunction

  // Width of the bank-row select; kept at 1 bit when there is only one row.
  function automatic int calc_vs_w(input int addr_w);
    return (addr_w > BANK_AW) ? (addr_w - BANK_AW) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/unisim_sram_bank_2048x8.sv
`default_nettype none
// ============================================================================
//  Module      : unisim_sram_bank_2048x8
//  Description : 2048x8 simple dual-port bank. One write port with per-bit
//                mask, one read port with a 1-cycle registered output that
//                returns the pre-write (old) contents on a same-row access.
//                Array contents are never reset.
//  Revision    : 1.0  initial release
// ============================================================================
module unisim_sram_bank_2048x8
  import unisim_sram_pkg::*;
(
  input  logic               clk_i,
  input  logic               wr_en_i,
  input  logic [BANK_AW-1:0] wr_addr_i,
  input  logic [BANK_W-1:0]  wr_data_i,
  input  logic [BANK_W-1:0]  wr_mask_i,
  input  logic               rd_en_i,
  input  logic [BANK_AW-1:0] rd_addr_i,
  output logic [BANK_W-1:0]  rd_data_o
);

  logic [BANK_W-1:0] mem_q [BANK_DEPTH];
  logic [BANK_W-1:0] rd_data_q;

  // Masked write: only bits with a set mask bit take the new value.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= (mem_q[wr_addr_i] & ~wr_mask_i) | (wr_data_i & wr_mask_i);
    end
  end

  // Registered read; holds its value when no read is issued.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/unisim_sram_b_param.sv
`default_nettype none
// ============================================================================
//  Module      : unisim_sram_b_param
//  Description : Parameterised SRAM built from 2048x8 banks, with 1-cycle
//                read latency, per-bit write mask and write/read collision
//                detection plus a saturating collision counter.
//                Build option: UNISIM_SRAM_B_BYPASS_EN selects write-first
//                data on a collision (read-first when undefined).
//  Revision    : 1.0  initial release
// ============================================================================
module unisim_sram_b_param
  import unisim_sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              CE0,
  input  logic [ADDR_W-1:0] A0,
  input  logic [DATA_W-1:0] D0,
  input  logic              WE0,
  input  logic [DATA_W-1:0] WEM0,
  input  logic              CE1,
  input  logic [ADDR_W-1:0] A1,
  output logic [DATA_W-1:0] Q1,
  output logic              Q1_VALID,
  output logic              COLL,
  output logic [15:0]       COLL_CNT
);

  localparam int NH   = calc_nh(DATA_W);
  localparam int NV   = calc_nv(ADDR_W);
  localparam int VS_W = calc_vs_w(ADDR_W);

  // Elaboration-time parameter legality checks.
  if ((DATA_W % BANK_W) != 0 || DATA_W < 8 || DATA_W > 64) begin : g_chk_data_w
    $error("unisim_sram_b_param: DATA_W=%0d must be a multiple of 8 in 8..64", DATA_W);
  end
  if (ADDR_W < 8 || ADDR_W > 14) begin : g_chk_addr_w
    $error("unisim_sram_b_param: ADDR_W=%0d must be in 8..14", ADDR_W);
  end

  logic [BANK_AW-1:0]           row0_w, row1_w;
  logic [VS_W-1:0]              vs0_w, vs1_w;
  logic                         wr_w, coll_w;
  logic [NV-1:0][DATA_W-1:0]    bank_rd_w;
  logic [DATA_W-1:0]            old_w, rd_word_w;

  logic [VS_W-1:0]              vsel_q;
  logic                         valid_q, coll_q, has_data_q;
  logic [15:0]                  cnt_q, cnt_d;

  // Address split: upper bits pick the bank row, low 11 bits the word row.
  if (ADDR_W > BANK_AW) begin : g_addr_tiled
    assign row0_w = A0[BANK_AW-1:0];
    assign row1_w = A1[BANK_AW-1:0];
    assign vs0_w  = A0[ADDR_W-1:BANK_AW];
    assign vs1_w  = A1[ADDR_W-1:BANK_AW];
  end else begin : g_addr_flat
    assign row0_w = BANK_AW'(A0);
    assign row1_w = BANK_AW'(A1);
    assign vs0_w  = '0;
    assign vs1_w  = '0;
  end

  assign wr_w   = CE0 & WE0;
  assign coll_w = wr_w & CE1 & (A0 == A1);

  // Bank array: each bank row only sees enables addressed to it.
  for (genvar v = 0; v < NV; v++) begin : g_vbank
    for (genvar h = 0; h < NH; h++) begin : g_hbank
      unisim_sram_bank_2048x8 u_bank (
        .clk_i     (CLK),
        .wr_en_i   (wr_w & (vs0_w == VS_W'(v))),
        .wr_addr_i (row0_w),
        .wr_data_i (D0[h*BANK_W +: BANK_W]),
        .wr_mask_i (WEM0[h*BANK_W +: BANK_W]),
        .rd_en_i   (CE1 & (vs1_w == VS_W'(v))),
        .rd_addr_i (row1_w),
        .rd_data_o (bank_rd_w[v][h*BANK_W +: BANK_W])
      );
    end
  end

  // Output steering uses the bank row captured with the read, not live A1.
  if (NV > 1) begin : g_rd_mux
    assign old_w = bank_rd_w[vsel_q];
  end else begin : g_rd_single
    assign old_w = bank_rd_w[0];
  end

  // Saturating collision count.
  always_comb begin
    cnt_d = cnt_q;
    if (coll_w && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Read pipeline, collision pulse and counter state.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vsel_q     <= '0;
      valid_q    <= 1'b0;
      coll_q     <= 1'b0;
      has_data_q <= 1'b0;
      cnt_q      <= 16'd0;
    end else begin
      valid_q <= CE1;
      coll_q  <= coll_w;
      cnt_q   <= cnt_d;
      if (CE1) begin
        vsel_q     <= vs1_w;
        has_data_q <= 1'b1;
      end
    end
  end

`ifdef UNISIM_SRAM_B_BYPASS_EN
  logic              fwd_q;
  logic [DATA_W-1:0] fwd_data_q, fwd_mask_q;

  // Capture masked write data alongside each read; it overrides the bank
  // output for the bits being written when that read collided.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      fwd_mask_q <= '0;
    end else if (CE1) begin
      fwd_q      <= coll_w;
      fwd_data_q <= D0 & WEM0;
      fwd_mask_q <= WEM0;
    end
  end

  assign rd_word_w = fwd_q ? (fwd_data_q | (old_w & ~fwd_mask_q)) : old_w;
`else
  assign rd_word_w = old_w;
`endif

  // Q1 reads as zero until the first read after reset completes.
  assign Q1       = has_data_q ? rd_word_w : '0;
  assign Q1_VALID = valid_q;
  assign COLL     = coll_q;
  assign COLL_CNT = cnt_q;

endmodule
`default_nettype wire

// File: doc/unisim_sram_b_param.md
UNISIM_SRAM_B_PARAM -- requirements
Module: unisim_sram_b_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits; legal values are multiples of 8, from 8 to 64.
REQ-002 SHALL have parameter ADDR_W, default 12, word address width; legal values are 8 to 14; depth is 2**ADDR_W.
REQ-003 SHALL have port CLK, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port RSTN, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port CE0, input, 1, write-port enable.
REQ-006 SHALL have port A0, input, ADDR_W, write address.
REQ-007 SHALL have port D0, input, DATA_W, write data.
REQ-008 SHALL have port WE0, input, 1, write enable, qualified by CE0.
REQ-009 SHALL have port WEM0, input, DATA_W, per-bit write mask (1 = write the bit).
REQ-010 SHALL have port CE1, input, 1, read-port enable.
REQ-011 SHALL have port A1, input, ADDR_W, read address.
REQ-012 SHALL have port Q1, output, DATA_W, read data.
REQ-013 SHALL have port Q1_VALID, output, 1, Q1 carries data from the read issued on the previous edge.
REQ-014 SHALL have port COLL, output, 1, one-cycle pulse on a same-address write/read collision.
REQ-015 SHALL have port COLL_CNT, output, 16, saturating collision count.

Function
REQ-016 SHALL tile the storage from 2048x8 banks: NH = DATA_W/8 horizontal banks and NV = max(1, 2**ADDR_W/2048) vertical banks; A[ADDR_W-1:11] selects the vertical bank and A[10:0] the row; when ADDR_W < 11 the unused upper row bits are tied to 0.
REQ-017 SHALL perform the write when CE0&WE0 are high at edge k: bits where WEM0=1 are written; bits where WEM0=0 are unchanged.
REQ-018 SHALL, when CE1 is high at edge k, drive the addressed word on Q1 after edge k+1 with Q1_VALID=1 for exactly that cycle (1-cycle latency, back-to-back reads allowed every cycle).
REQ-019 SHALL register the vertical-bank select at edge k and use it to steer the Q1 mux at k+1, independently of A1 changes at k+1.
REQ-020 SHALL hold Q1 at its last read value while no read completes; Q1_VALID=0 in those cycles.
REQ-021 SHALL define a collision as CE0&WE0&CE1 high with A0==A1 at the same edge; it SHALL pulse COLL at k+1 for one cycle.
REQ-022 SHALL increment COLL_CNT once per collision and saturate at 16'hFFFF with no wrap.
REQ-023 SHALL treat a write and a read to different banks, or to different rows of the same bank, in the same cycle as independent, with no stall and no COLL.

Reset
REQ-024 SHALL, while RSTN=0, force Q1=0, Q1_VALID=0, COLL=0, COLL_CNT=0 and the registered bank select to 0, immediately and asynchronously.
REQ-025 SHALL NOT reset the memory array contents.
REQ-026 SHALL discard a read issued on the edge where reset asserts: no Q1_VALID follows it after reset release.
REQ-027 SHALL accept operations from the first rising edge on which RSTN=1.

Configuration
REQ-028 SHALL, when macro UNISIM_SRAM_B_BYPASS_EN is defined, return write-first data on a collision: Q1 = (D0 & WEM0) | (old & ~WEM0), produced by a registered forward path.
REQ-029 SHALL, when UNISIM_SRAM_B_BYPASS_EN is undefined, return read-first (old) data on a collision.
REQ-030 SHALL pulse COLL and count it in COLL_CNT in both builds.

Structure
REQ-031 SHALL place BANK_W=8, BANK_AW=11, and the functions deriving NH and NV from DATA_W and ADDR_W in shared package unisim_sram_pkg.
REQ-032 SHALL instantiate one sub-module, unisim_sram_bank_2048x8: a dual-port, 1-cycle-read, per-bit-mask bank.
REQ-033 SHALL contain simulation-only assertions that flag illegal parameters at elaboration; they SHALL NOT call $finish on collisions.

Verification
REQ-034 SHALL cover: DATA_W=32, ADDR_W=12; write 0xDEADBEEF to address 0x005 and 0xCAFEF00D to 0x805, mask all-ones, then read 0x005 and 0x805 back-to-back -> Q1 = 0xDEADBEEF then 0xCAFEF00D on consecutive cycles, Q1_VALID high for both.
REQ-035 SHALL cover: address 0x010 holds 0x11223344; write 0xAABBCCDD with WEM0=0x0000FFFF, then read -> Q1=0x1122CCDD.
REQ-036 SHALL cover: address 0x020 holds 0x0; in the same cycle write 0x12345678 with full mask and read 0x020 -> Q1=0x12345678 with BYPASS_EN, 0x00000000 without; COLL=1 for one cycle; COLL_CNT=1.
REQ-037 SHALL cover: force COLL_CNT to 0xFFFE, then perform 3 collisions -> COLL_CNT=0xFFFF, and COLL still pulses on each.
REQ-038 SHALL cover: issue a read of 0x030, assert RSTN low at that edge, release 2 cycles later -> Q1=0, Q1_VALID stays 0, and data written before the reset is still read back afterwards.
REQ-039 SHALL cover: DATA_W=8, ADDR_W=8 -> a single bank; write/read all 256 addresses with the pattern addr^0x5A -> all match, and COLL never asserts.
